// File: rtl/mod10_pkg.sv
// Shared types for the mod-10 decade tracker: BCD digit, snapshot layout and tracker FSM states.
package mod10_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t MAX_DIGIT = 4'd9;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    HOLD  = 2'd2
  } trk_state_e;

  typedef struct packed {
    bcd_digit_t hundreds;
    bcd_digit_t tens;
    bcd_digit_t units;
  } bcd_snap_t;

endpackage

// File: rtl/mod10_snap_fifo.sv
// Synchronous snapshot FIFO; a push into a full FIFO is accepted only when a pop frees a slot
// at the same edge.
module mod10_snap_fifo
  import mod10_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  bcd_snap_t push_data,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output bcd_snap_t head
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  bcd_snap_t mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign head  = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    push_ok  = push && (!full || pop);
    pop_ok   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/mod10_decade_tracker.sv
// Watches a mod-10 counter, extends it with BCD tens/hundreds on 9->0 carries and 0->9 borrows,
// and queues each resulting 3-digit snapshot.
// state | meaning
// SYNC  | no valid previous sample
// TRACK | previous sample valid, detection active
// HOLD  | skip the transition caused by a load
module mod10_decade_tracker
  import mod10_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cnt_rst,
  input  logic        cnt_mode,
  input  logic        cnt_load,
  input  logic [3:0]  cnt_data,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [11:0] out_bcd,
  output logic        err_illegal,
  output logic        ovf,
  output logic        unf,
  output logic        drop
);

  trk_state_e state_q, state_d;
  bcd_digit_t tens_q, tens_d;
  bcd_digit_t hund_q, hund_d;
  bcd_digit_t prev_q, prev_d;
  logic       err_q, err_d, ovf_q, ovf_d, unf_q, unf_d, drop_q, drop_d;
  logic       carry, borrow, push, pop, fifo_full, fifo_empty;
  bcd_snap_t  snap, fifo_head;

  assign pop         = out_valid && out_ready;
  assign out_valid   = !fifo_empty;
  assign out_bcd     = fifo_head;
  assign err_illegal = err_q;
  assign ovf         = ovf_q;
  assign unf         = unf_q;
  assign drop        = drop_q;

  always_comb begin
    state_d = state_q;
    tens_d  = tens_q;
    hund_d  = hund_q;
    prev_d  = prev_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    drop_d  = drop_q;
    carry   = 1'b0;
    borrow  = 1'b0;
    if (cnt_rst) begin
      state_d = SYNC;
      tens_d  = '0;
      hund_d  = '0;
    end else if (cnt_data > MAX_DIGIT) begin
      err_d   = 1'b1;
      state_d = SYNC;
    end else begin
      prev_d = cnt_data;
      if (cnt_load) begin
        state_d = HOLD;
      end else if (state_q != TRACK) begin
        state_d = TRACK;
      end else begin
        carry  = cnt_mode && (prev_q == MAX_DIGIT) && (cnt_data == 4'd0);
        borrow = !cnt_mode && (prev_q == 4'd0) && (cnt_data == MAX_DIGIT);
      end
    end

    if (carry) begin
      if (tens_q == MAX_DIGIT) begin
        tens_d = '0;
        if (hund_q == MAX_DIGIT) begin
          hund_d = '0;
          ovf_d  = 1'b1;
        end else begin
          hund_d = hund_q + 4'd1;
        end
      end else begin
        tens_d = tens_q + 4'd1;
      end
    end

    // Borrowing from 000 lands on 990 because units already reads 9.
    if (borrow) begin
      if (tens_q == 4'd0) begin
        tens_d = MAX_DIGIT;
        if (hund_q == 4'd0) begin
          hund_d = MAX_DIGIT;
          unf_d  = 1'b1;
        end else begin
          hund_d = hund_q - 4'd1;
        end
      end else begin
        tens_d = tens_q - 4'd1;
      end
    end

    push          = carry || borrow;
    snap.hundreds = hund_d;
    snap.tens     = tens_d;
    snap.units    = cnt_data;
    if (push && fifo_full && !pop) drop_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SYNC;
      tens_q  <= '0;
      hund_q  <= '0;
      prev_q  <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tens_q  <= tens_d;
      hund_q  <= hund_d;
      prev_q  <= prev_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      drop_q  <= drop_d;
    end
  end

  mod10_snap_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (snap),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

endmodule

// File: tb/tb_mod10_decade_tracker.sv
// Directed bench for mod10_decade_tracker: expected snapshots are queued at stimulus time
// and compared by an independent monitor as the DUT presents them.
module tb_mod10_decade_tracker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cnt_rst = 1'b0;
  logic        cnt_mode = 1'b1;
  logic        cnt_load = 1'b0;
  logic [3:0]  cnt_data = 4'd0;
  logic        out_ready = 1'b1;
  logic        out_valid;
  logic [11:0] out_bcd;
  logic        err_illegal, ovf, unf, drop;

  int tests = 0;
  int fails = 0;
  logic [11:0] sb [$];

  always #5 clk = ~clk;

  mod10_decade_tracker #(.FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .cnt_rst     (cnt_rst),
    .cnt_mode    (cnt_mode),
    .cnt_load    (cnt_load),
    .cnt_data    (cnt_data),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_bcd     (out_bcd),
    .err_illegal (err_illegal),
    .ovf         (ovf),
    .unf         (unf),
    .drop        (drop)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // A pop happens at the next posedge whenever valid && ready hold at the negedge before it.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_snapshot: got %0h expected none", out_bcd);
      end else begin
        chk("snapshot", {20'd0, out_bcd}, {20'd0, sb.pop_front()});
      end
    end
  end

  task automatic cyc(input logic [3:0] d, input logic m, input logic ld = 1'b0,
                     input logic crst = 1'b0);
    cnt_data = d;
    cnt_mode = m;
    cnt_load = ld;
    cnt_rst  = crst;
    @(posedge clk);
    #1;
    cnt_load = 1'b0;
    cnt_rst  = 1'b0;
  endtask

  task automatic up_decade();
    for (int d = 1; d <= 9; d++) cyc(4'(d), 1'b1);
    cyc(4'd0, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [11:0] up_exp [12];
    logic [11:0] head0;
    up_exp = '{12'h010, 12'h020, 12'h030, 12'h040, 12'h050, 12'h060,
               12'h070, 12'h080, 12'h090, 12'h100, 12'h110, 12'h120};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_valid", {31'd0, out_valid}, 0);
    chk("reset_bcd", {20'd0, out_bcd}, 0);
    chk("reset_flags", {28'd0, err_illegal, ovf, unf, drop}, 0);

    // Count up: 12 decades, first one checks push latency.
    cyc(4'd0, 1'b1);
    sb.push_back(up_exp[0]);
    for (int d = 1; d <= 9; d++) cyc(4'(d), 1'b1);
    chk("valid_before_wrap", {31'd0, out_valid}, 0);
    cyc(4'd0, 1'b1);
    chk("valid_after_wrap", {31'd0, out_valid}, 1);
    chk("first_snapshot_head", {20'd0, out_bcd}, 32'h010);
    for (int k = 1; k < 12; k++) begin
      sb.push_back(up_exp[k]);
      up_decade();
    end
    idle(3);
    chk("up_queue_drained", sb.size(), 0);

    // Load jump 9 -> 0 is skipped.
    cyc(4'd0, 1'b1, 1'b0, 1'b1);
    for (int d = 5; d <= 8; d++) cyc(4'(d), 1'b1);
    cyc(4'd9, 1'b1, 1'b1);
    cyc(4'd0, 1'b1);
    idle(2);
    chk("load_no_snapshot", {31'd0, out_valid}, 0);
    sb.push_back(12'h010);
    up_decade();
    idle(3);
    chk("load_queue_drained", sb.size(), 0);

    // Down from zeroed digits: underflow to 990, then 980.
    cyc(4'd0, 1'b0, 1'b0, 1'b1);
    cyc(4'd1, 1'b0);
    cyc(4'd0, 1'b0);
    sb.push_back(12'h999);
    cyc(4'd9, 1'b0);
    chk("unf_set", {31'd0, unf}, 1);
    sb.push_back(12'h989);
    for (int d = 8; d >= 0; d--) cyc(4'(d), 1'b0);
    cyc(4'd9, 1'b0);
    idle(3);
    chk("down_queue_drained", sb.size(), 0);

    // Backpressure: 5 carries into a 4-deep FIFO.
    cyc(4'd0, 1'b1, 1'b0, 1'b1);
    cyc(4'd0, 1'b1);
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) up_decade();
    chk("drop_set", {31'd0, drop}, 1);
    chk("full_head", {20'd0, out_bcd}, 32'h010);
    head0 = out_bcd;
    idle(3);
    chk("head_stable", {20'd0, out_bcd}, {20'd0, head0});
    sb.push_back(12'h010);
    sb.push_back(12'h020);
    sb.push_back(12'h030);
    sb.push_back(12'h040);
    out_ready = 1'b1;
    idle(4);
    chk("drain_consecutive", {31'd0, out_valid}, 0);
    chk("drain_all_popped", sb.size(), 0);

    // Illegal value breaks tracking; the following 0 is only a resync sample.
    cyc(4'd0, 1'b1, 1'b0, 1'b1);
    cyc(4'd0, 1'b1);
    for (int d = 1; d <= 9; d++) cyc(4'(d), 1'b1);
    cyc(4'd12, 1'b1);
    chk("err_set", {31'd0, err_illegal}, 1);
    cyc(4'd0, 1'b1);
    idle(2);
    chk("illegal_no_snapshot", {31'd0, out_valid}, 0);
    sb.push_back(12'h010);
    up_decade();
    idle(3);
    chk("illegal_queue_drained", sb.size(), 0);

    // 990 plus one carry wraps to 000 with ovf.
    cyc(4'd0, 1'b0, 1'b0, 1'b1);
    cyc(4'd1, 1'b0);
    cyc(4'd0, 1'b0);
    sb.push_back(12'h999);
    cyc(4'd9, 1'b0);
    sb.push_back(12'h000);
    cyc(4'd0, 1'b1);
    chk("ovf_set", {31'd0, ovf}, 1);
    idle(3);
    chk("ovf_queue_drained", sb.size(), 0);

    // Three queued entries flushed by rst.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) up_decade();
    chk("queued_before_rst", {31'd0, out_valid}, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_flush_valid", {31'd0, out_valid}, 0);
    chk("rst_flush_bcd", {20'd0, out_bcd}, 0);
    chk("rst_flags", {28'd0, err_illegal, ovf, unf, drop}, 0);
    out_ready = 1'b1;
    idle(3);
    chk("final_queue_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
